// File: rtl/sprite_fetch_sched_if.sv
// sprite_fetch_sched_if: shared sprite ROM port and line buffer write port
interface sprite_fetch_sched_if;
  logic [1:0]  rom_sel;
  logic [9:0]  rom_addr;
  logic [11:0] rom_q;
  logic        lb_we;
  logic [9:0]  lb_waddr;
  logic [3:0]  lb_wdata;
  logic        lb_bank;
  modport master (output rom_sel, rom_addr, lb_we, lb_waddr, lb_wdata, lb_bank, input rom_q);
  modport slave  (input rom_sel, rom_addr, lb_we, lb_waddr, lb_wdata, lb_bank, output rom_q);
endinterface

// File: rtl/sprite_fetch_sched.sv
// sprite_fetch_sched: hblank sprite ROM fetch into a ping-pong line buffer
module sprite_fetch_sched #(
  parameter int NSPRITE  = 3,
  parameter int SPRITE_W = 32,
  parameter int ROM_LAT  = 2,
  parameter int HSTART   = 1280,
  parameter int HTOTAL   = 1600,
  parameter int VACTIVE  = 480,
  parameter int VTOTAL   = 525
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [10:0]            hcount,
  input  logic [9:0]             vcount,
  input  logic [10*NSPRITE-1:0]  sprite_x,
  input  logic [10*NSPRITE-1:0]  sprite_y,
  input  logic [5*NSPRITE-1:0]   sprite_img,
  sprite_fetch_sched_if.master   bus,
  output logic                   busy,
  output logic                   overrun
);
  localparam int SW = NSPRITE > 1 ? $clog2(NSPRITE) : 1;
  localparam int DW = $clog2(ROM_LAT + 2);
  typedef enum logic [1:0] {IDLE, SCAN, FETCH, DRAIN} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [9:0] t_q, t_d;
  logic [10*NSPRITE-1:0] x_q, x_d, y_q, y_d;
  logic [5*NSPRITE-1:0] img_q, img_d;
  logic [1:0] sel_q, sel_d;
  logic [9:0] addr_q, addr_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [ROM_LAT-1:0] pv_q, pv_d;
  logic [ROM_LAT-1:0][1:0] ps_q, ps_d;
  logic [ROM_LAT-1:0][10:0] pp_q, pp_d;
  logic we_q, we_d, bank_q, bank_d, busy_q, busy_d, overrun_q, overrun_d;
  logic [9:0] waddr_q, waddr_d;
  logic [3:0] wdata_q, wdata_d;
  logic [9:0] cur_x, cur_y, tgt;
  logic [4:0] cur_img;
  logic [10:0] diff, px, pxo;
  logic [3:0] nib;
  logic hit, eol, trig;
  assign cur_x   = x_q[10*slot_q +: 10];
  assign cur_y   = y_q[10*slot_q +: 10];
  assign cur_img = img_q[5*slot_q +: 5];
  // row offset within the sprite; sign bit set means the target row is above it
  assign diff = {1'b0, t_q} - {2'b0, cur_y[9:1]} + 11'(SPRITE_W/2);
  assign hit  = cur_y[0] && (cur_img <= 5'd2) && !diff[10] && (diff < 11'(SPRITE_W));
  assign px   = {1'b0, cur_x} - 11'(SPRITE_W/2) + {6'b0, addr_q[4:0]};
  assign tgt  = (vcount == 10'(VTOTAL-1)) ? 10'd0 : vcount + 10'd1;
  assign eol  = hcount == 11'(HTOTAL-1);
  assign trig = hcount == 11'(HSTART);
  assign pxo  = pp_q[ROM_LAT-1];
  assign nib  = bus.rom_q[4*ps_q[ROM_LAT-1] +: 4];
  always_comb begin
    state_d = state_q;
    slot_d = slot_q;
    t_d = t_q;
    x_d = x_q;
    y_d = y_q;
    img_d = img_q;
    sel_d = sel_q;
    addr_d = addr_q;
    drain_d = drain_q;
    pv_d[0] = state_q == FETCH;
    ps_d[0] = sel_q;
    pp_d[0] = px;
    for (int i = ROM_LAT-1; i > 0; i--) begin
      pv_d[i] = pv_q[i-1];
      ps_d[i] = ps_q[i-1];
      pp_d[i] = pp_q[i-1];
    end
    we_d = pv_q[ROM_LAT-1] && (nib != 4'd0) && !pxo[10] && (pxo < 11'd640);
    waddr_d = pxo[9:0];
    wdata_d = nib;
    bank_d = bank_q ^ eol;
    overrun_d = eol && (state_q != IDLE);
    if (eol) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        pv_d = '0;
        we_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: if (trig) begin
          x_d = sprite_x;
          y_d = sprite_y;
          img_d = sprite_img;
          t_d = tgt;
          slot_d = SW'(NSPRITE-1);
          state_d = tgt < 10'(VACTIVE) ? SCAN : IDLE;
        end
        SCAN: begin
          drain_d = '0;
          if (hit) begin
            state_d = FETCH;
            sel_d = cur_img[1:0];
            addr_d = {diff[4:0], 5'd0};
          end else begin
            state_d = slot_q == '0 ? DRAIN : SCAN;
            slot_d = slot_q == '0 ? slot_q : slot_q - SW'(1);
          end
        end
        FETCH: begin
          drain_d = '0;
          addr_d[4:0] = addr_q[4:0] + 5'd1;
          if (addr_q[4:0] == 5'(SPRITE_W-1)) begin
            state_d = slot_q == '0 ? DRAIN : SCAN;
            slot_d = slot_q == '0 ? slot_q : slot_q - SW'(1);
          end
        end
        default: begin
          drain_d = drain_q + DW'(1);
          state_d = drain_q == DW'(ROM_LAT+1) ? IDLE : DRAIN;
        end
      endcase
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      slot_q <= '0;
      t_q <= '0;
      x_q <= '0;
      y_q <= '0;
      img_q <= '0;
      sel_q <= '0;
      addr_q <= '0;
      drain_q <= '0;
      pv_q <= '0;
      ps_q <= '0;
      pp_q <= '0;
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      bank_q <= 1'b0;
      busy_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      t_q <= t_d;
      x_q <= x_d;
      y_q <= y_d;
      img_q <= img_d;
      sel_q <= sel_d;
      addr_q <= addr_d;
      drain_q <= drain_d;
      pv_q <= pv_d;
      ps_q <= ps_d;
      pp_q <= pp_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      bank_q <= bank_d;
      busy_q <= busy_d;
      overrun_q <= overrun_d;
    end
  end
  assign bus.rom_sel  = sel_q;
  assign bus.rom_addr = addr_q;
  assign bus.lb_we    = we_q;
  assign bus.lb_waddr = waddr_q;
  assign bus.lb_wdata = wdata_q;
  assign bus.lb_bank  = bank_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;
endmodule
